mipi_csi2_deser: RTL
====================

// Module: mipi_csi2_deser
// PURPOSE
//  CSI-2 receive depacketizer: consumes the byte stream recovered by the PHY deserializer and regenerates
//  the vsync/href/pixel parallel interface that feeds the transmit serializer. Decodes short packets
//  (FS=0x00, FE=0x01, LS=0x02, LE=0x03) and long RAW8 (0x2A) / RAW10 (0x2B) packets; unpacks RAW10.
// PARAMETERS
//  DATA_WIDTH  10     output pixel width (>=10)
//  ECC_VALUE   8'hEC  expected header ECC byte (fixed, matches transmitter)
//  CHECK_ECC   1      1: compare ECC byte, pulse ecc_err and drop packet on mismatch
// PORTS
//  pixclk      in   1           clock
//  resetb      in   1           reset, asynchronous, active-low
//  enable      in   1           0: FSM to IDLE, outputs cleared on next edge
//  in_valid    in   1           in_data valid this cycle; gaps allowed anywhere
//  in_sop      in   1           qualifies in_valid: byte is first (data_id) of a packet
//  in_data     in   8           packet byte
//  data        out  DATA_WIDTH  pixel; RAW8 zero-extended, RAW10 {msb8,lsb2}
//  pix_valid   out  1           data valid
//  href        out  1           line window: first to last pixel of a long packet
//  vsync       out  1           frame window: FS..FE
//  pixel_width out  4           8 or 10, data type of current/last long packet
//  frame_num   out  16          WC field of last FS
//  line_wc     out  16          WC field of last long packet
//  checksum    out  16          trailer of last long packet, {hi,lo}; not checked
//  ecc_err     out  1           1-cycle pulse
//  abort_err   out  1           1-cycle pulse: in_sop while packet in progress
//  len_err     out  1           1-cycle pulse: RAW10 WC not a multiple of 5
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; unpack buffer empty. Async, any cycle, mid-packet included.
//  FSM advances only on in_valid. States: IDLE->WC0->WC1->ECC->{IDLE | PAYLOAD->CRC0->CRC1->IDLE}.
//   IDLE: in_valid&in_sop latches data_id; in_valid without in_sop ignored.
//   WC0/WC1: WC little-endian. ECC: if CHECK_ECC & byte!=ECC_VALUE -> ecc_err, IDLE, packet dropped.
//   Short: FS -> vsync=1, frame_num=WC; FE -> vsync=0; LS/LE no effect; all take effect cycle after ECC byte.
//   FS while vsync=1: vsync stays 1, frame_num updated. FE while vsync=0: no change.
//   Long 0x2A/0x2B: line_wc=WC, pixel_width=8/10, byte counter=WC; WC=0 -> straight to CRC0.
//   Other data_id: treated as long, payload consumed and discarded, no pixels.
//   PAYLOAD decrements counter per byte; last byte -> CRC0; CRC0/CRC1 load checksum[7:0]/[15:8].
//  RAW8: payload byte at edge n -> data={0,byte}, pix_valid=1 at n+1.
//  RAW10: bytes M0..M3 buffered, 5th byte L -> pixel k={Mk,L[2k+1:2k]}; pixel0 at n+1 after L
//   accepted at n, pixels 1..3 at n+2..n+4 regardless of in_valid. Next group needs >=5 bytes so
//   buffer never overflows. Trailing 1-4 bytes (WC%5!=0): discarded, len_err pulses at CRC0 entry.
//  href: rises with first pix_valid of packet; stays high across gaps; falls cycle after last pixel.
//   pix_valid without href never occurs. href outside vsync allowed (no gating).
//  in_sop while FSM!=IDLE: abort_err, pending RAW10 pixels flushed, href->0 next cycle, byte starts
//   new header (WC0 next). vsync unaffected.
//  Width: counters 16 bit, no wrap; WC=0xFFFF legal.
// TESTING
//  FS bytes 00,05,00,EC -> vsync 1 one cycle after EC, frame_num=0x0005; FE 01,05,00,EC -> vsync 0.
//  RAW8 2A,04,00,EC,11,22,33,44,CD,AB back-to-back -> pix_valid 4 cycles data 0x011..0x044, href
//   4 cycles, checksum=0xABCD.
//  RAW10 2B,05,00,EC,12,34,56,78,E4 -> data 0x048,0x0D1,0x15A,0x1E3 on 4 consecutive cycles.
//  Header 00,05,00,ED with CHECK_ECC=1 -> ecc_err 1 cycle, vsync unchanged.
//  RAW8 WC=8, in_sop at 3rd payload byte -> abort_err, href falls, new header decoded correctly.
//  RAW10 WC=7 -> 4 pixels then len_err; resetb low mid-payload -> all outputs 0 immediately.

Source files
------------

// File: rtl/mipi_csi2_deser.sv
// CSI-2 receive depacketizer: decodes short/long packets from the PHY byte stream and
// regenerates vsync/href/pixel timing, unpacking RAW8 and RAW10 payloads.
module mipi_csi2_deser #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter logic [7:0]  ECC_VALUE  = 8'hEC,
    parameter bit          CHECK_ECC  = 1'b1
) (
    input  logic                  pixclk,
    input  logic                  resetb,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic [7:0]            in_data,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  pix_valid,
    output logic                  href,
    output logic                  vsync,
    output logic [3:0]            pixel_width,
    output logic [15:0]           frame_num,
    output logic [15:0]           line_wc,
    output logic [15:0]           checksum,
    output logic                  ecc_err,
    output logic                  abort_err,
    output logic                  len_err
);
    localparam int unsigned PIX_W    = 10;
    localparam logic [7:0]  DT_FS    = 8'h00;
    localparam logic [7:0]  DT_FE    = 8'h01;
    localparam logic [7:0]  DT_RAW8  = 8'h2A;
    localparam logic [7:0]  DT_RAW10 = 8'h2B;

    typedef enum logic [2:0] {
        S_IDLE, S_WC0, S_WC1, S_ECC, S_PAYLOAD, S_CRC0, S_CRC1
    } state_t;

    state_t                    state_q;
    logic [7:0]                dt_q;
    logic [15:0]               wc_q;
    logic [15:0]               cnt_q;
    logic [3:0][7:0]           mbuf_q;
    logic [2:0]                mcnt_q;
    logic [2:0][PIX_W-1:0]     sr_q;
    logic [1:0]                pend_q;
    logic                      grp_last_q;
    logic                      pix_last_q;

    logic [DATA_WIDTH-1:0]     data_q;
    logic                      pix_valid_q, href_q, vsync_q;
    logic [3:0]                pixel_width_q;
    logic [15:0]               frame_num_q, line_wc_q, checksum_q;
    logic                      ecc_err_q, abort_err_q, len_err_q;

    // RAW10 pixels completed by the current byte acting as the lsb byte of a group
    logic [PIX_W-1:0] pix0_c, pix1_c, pix2_c, pix3_c;
    assign pix0_c = {mbuf_q[0], in_data[1:0]};
    assign pix1_c = {mbuf_q[1], in_data[3:2]};
    assign pix2_c = {mbuf_q[2], in_data[5:4]};
    assign pix3_c = {mbuf_q[3], in_data[7:6]};

    always_ff @(posedge pixclk or negedge resetb) begin
        if (!resetb) begin
            state_q       <= S_IDLE;
            dt_q          <= '0;
            wc_q          <= '0;
            cnt_q         <= '0;
            mbuf_q        <= '0;
            mcnt_q        <= '0;
            sr_q          <= '0;
            pend_q        <= '0;
            grp_last_q    <= 1'b0;
            pix_last_q    <= 1'b0;
            data_q        <= '0;
            pix_valid_q   <= 1'b0;
            href_q        <= 1'b0;
            vsync_q       <= 1'b0;
            pixel_width_q <= '0;
            frame_num_q   <= '0;
            line_wc_q     <= '0;
            checksum_q    <= '0;
            ecc_err_q     <= 1'b0;
            abort_err_q   <= 1'b0;
            len_err_q     <= 1'b0;
        end else if (!enable) begin
            state_q       <= S_IDLE;
            dt_q          <= '0;
            wc_q          <= '0;
            cnt_q         <= '0;
            mbuf_q        <= '0;
            mcnt_q        <= '0;
            sr_q          <= '0;
            pend_q        <= '0;
            grp_last_q    <= 1'b0;
            pix_last_q    <= 1'b0;
            data_q        <= '0;
            pix_valid_q   <= 1'b0;
            href_q        <= 1'b0;
            vsync_q       <= 1'b0;
            pixel_width_q <= '0;
            frame_num_q   <= '0;
            line_wc_q     <= '0;
            checksum_q    <= '0;
            ecc_err_q     <= 1'b0;
            abort_err_q   <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            pix_valid_q <= 1'b0;
            ecc_err_q   <= 1'b0;
            abort_err_q <= 1'b0;
            len_err_q   <= 1'b0;
            pix_last_q  <= 1'b0;
            if (pix_last_q) href_q <= 1'b0;

            // Drain RAW10 pixels 1..3 of the last group, one per cycle
            if (pend_q != 2'd0) begin
                data_q      <= DATA_WIDTH'(sr_q[0]);
                sr_q[0]     <= sr_q[1];
                sr_q[1]     <= sr_q[2];
                pend_q      <= pend_q - 2'd1;
                pix_valid_q <= 1'b1;
                href_q      <= 1'b1;
                pix_last_q  <= grp_last_q && (pend_q == 2'd1);
            end

            if (in_valid) begin
                if (in_sop && state_q != S_IDLE) begin
                    abort_err_q <= 1'b1;
                    pend_q      <= '0;
                    mcnt_q      <= '0;
                    pix_valid_q <= 1'b0;
                    pix_last_q  <= 1'b0;
                    href_q      <= 1'b0;
                    dt_q        <= in_data;
                    state_q     <= S_WC0;
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            if (in_sop) begin
                                dt_q    <= in_data;
                                state_q <= S_WC0;
                            end
                        end
                        S_WC0: begin
                            wc_q[7:0] <= in_data;
                            state_q   <= S_WC1;
                        end
                        S_WC1: begin
                            wc_q[15:8] <= in_data;
                            state_q    <= S_ECC;
                        end
                        S_ECC: begin
                            if (CHECK_ECC && in_data != ECC_VALUE) begin
                                ecc_err_q <= 1'b1;
                                state_q   <= S_IDLE;
                            end else if (dt_q[7:2] == 6'd0) begin
                                if (dt_q == DT_FS) begin
                                    vsync_q     <= 1'b1;
                                    frame_num_q <= wc_q;
                                end else if (dt_q == DT_FE) begin
                                    vsync_q <= 1'b0;
                                end
                                state_q <= S_IDLE;
                            end else begin
                                line_wc_q <= wc_q;
                                cnt_q     <= wc_q;
                                mcnt_q    <= '0;
                                if (dt_q == DT_RAW8)  pixel_width_q <= 4'd8;
                                if (dt_q == DT_RAW10) pixel_width_q <= 4'd10;
                                state_q <= (wc_q == 16'd0) ? S_CRC0 : S_PAYLOAD;
                            end
                        end
                        S_PAYLOAD: begin
                            cnt_q <= cnt_q - 16'd1;
                            if (dt_q == DT_RAW8) begin
                                data_q      <= DATA_WIDTH'(in_data);
                                pix_valid_q <= 1'b1;
                                href_q      <= 1'b1;
                                pix_last_q  <= (cnt_q == 16'd1);
                            end else if (dt_q == DT_RAW10) begin
                                if (mcnt_q != 3'd4) begin
                                    mbuf_q[mcnt_q[1:0]] <= in_data;
                                    mcnt_q              <= mcnt_q + 3'd1;
                                end else begin
                                    data_q      <= DATA_WIDTH'(pix0_c);
                                    pix_valid_q <= 1'b1;
                                    href_q      <= 1'b1;
                                    sr_q        <= {pix3_c, pix2_c, pix1_c};
                                    pend_q      <= 2'd3;
                                    grp_last_q  <= (cnt_q < 16'd6);
                                    mcnt_q      <= '0;
                                end
                            end
                            // Last payload byte: any partial RAW10 group is dropped
                            if (cnt_q == 16'd1) begin
                                len_err_q <= (dt_q == DT_RAW10) && (mcnt_q != 3'd4);
                                mcnt_q    <= '0;
                                state_q   <= S_CRC0;
                            end
                        end
                        S_CRC0: begin
                            checksum_q[7:0] <= in_data;
                            state_q         <= S_CRC1;
                        end
                        S_CRC1: begin
                            checksum_q[15:8] <= in_data;
                            state_q          <= S_IDLE;
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign data        = data_q;
    assign pix_valid   = pix_valid_q;
    assign href        = href_q;
    assign vsync       = vsync_q;
    assign pixel_width = pixel_width_q;
    assign frame_num   = frame_num_q;
    assign line_wc     = line_wc_q;
    assign checksum    = checksum_q;
    assign ecc_err     = ecc_err_q;
    assign abort_err   = abort_err_q;
    assign len_err     = len_err_q;

endmodule
